// File: rtl/uart_digit_rx_pkg.sv
// Shared types and constants for the UART digit receiver.
// Holds the bit-FSM state enum, ASCII digit bounds and digit count.
// Optional macro RX_PARITY_EN adds the PARITY state.
package uart_digit_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RX_PARITY_EN
        PARITY,
`endif
        STOP
    } rx_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam int NUM_DIGITS = 4;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Oversampling UART byte receiver: synchronizer, tick divider, bit FSM.
// Ports: clk, rst (async high), rxd (serial, idle high, LSB first),
//   data (received byte), byte_ok / byte_bad (combinational, valid in
//   the stop-sample cycle), busy (not IDLE).
// Macro RX_PARITY_EN: even parity bit between bit 7 and stop.
module uart_rx_byte
    import uart_digit_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       byte_ok,
    output logic       byte_bad,
    output logic       busy
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

    logic          sync1, sync2, rxd_s;
    rx_state_t     state, state_next;
    logic [DW-1:0] div_cnt;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          tick, start_det, sample;
    logic          stop_ok;

    // Sync flops reset high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
        end
    end

    assign rxd_s     = sync2;
    assign start_det = (state == IDLE) && !rxd_s;
    assign tick      = (div_cnt == DIV_LAST);
    // Start bit is checked at its centre; every later bit a full bit on.
    assign sample    = tick && (tick_cnt ==
                       ((state == START) ? HALF_LAST : FULL_LAST));
    assign busy      = (state != IDLE);
    assign data      = shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (start_det || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (state == IDLE || sample) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

`ifdef RX_PARITY_EN
    logic par_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err <= 1'b0;
        end else if (start_det) begin
            par_err <= 1'b0;
        end else if (state == PARITY && sample) begin
            // Even parity: data plus parity bit must have even weight.
            par_err <= ^{shreg, rxd_s};
        end
    end

    assign stop_ok = rxd_s && !par_err;
`else
    assign stop_ok = rxd_s;
`endif

    always_comb begin
        state_next = state;
        byte_ok    = 1'b0;
        byte_bad   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rxd_s) state_next = START;
            end
            START: begin
                if (sample) state_next = rxd_s ? IDLE : DATA;
            end
            DATA: begin
                if (sample && bit_cnt == 3'd7) begin
`ifdef RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (sample) state_next = STOP;
            end
`endif
            STOP: begin
                if (sample) begin
                    state_next = IDLE;
                    byte_ok    = stop_ok;
                    byte_bad   = !stop_ok;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (start_det) begin
            bit_cnt <= '0;
        end else if (state == DATA && sample) begin
            shreg   <= {rxd_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/uart_digit_rx.sv
// Receives ASCII digits over UART and shows groups of four on LED0..LED3.
// Ports: clk, rst (async high), Rxd (serial in), LED0..LED3 (digits,
//   LED0 first received), digits_valid / frame_err / char_err (one-cycle
//   pulses), busy (byte in progress).
// Macro RX_PARITY_EN: even parity; a parity mismatch counts as frame_err.
module uart_digit_rx
    import uart_digit_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rxd,
    output logic [3:0] LED0,
    output logic [3:0] LED1,
    output logic [3:0] LED2,
    output logic [3:0] LED3,
    output logic       digits_valid,
    output logic       frame_err,
    output logic       char_err,
    output logic       busy
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_DIGITS - 1);

    logic [7:0] rx_data;
    logic       byte_ok;
    logic       byte_bad;
    logic [1:0] idx;
    logic [3:0] shadow [NUM_DIGITS];

    uart_rx_byte #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rxd      (Rxd),
        .data     (rx_data),
        .byte_ok  (byte_ok),
        .byte_bad (byte_bad),
        .busy     (busy)
    );

    // byte_ok/byte_bad are mutually exclusive, so at most one pulse fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx          <= '0;
            LED0         <= '0;
            LED1         <= '0;
            LED2         <= '0;
            LED3         <= '0;
            digits_valid <= 1'b0;
            frame_err    <= 1'b0;
            char_err     <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= '0;
        end else begin
            digits_valid <= 1'b0;
            frame_err    <= 1'b0;
            char_err     <= 1'b0;
            if (byte_bad) begin
                frame_err <= 1'b1;
                idx       <= '0;
            end else if (byte_ok) begin
                if (!is_digit(rx_data)) begin
                    char_err <= 1'b1;
                    idx      <= '0;
                    for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= '0;
                end else if (idx == LAST_IDX) begin
                    // Last digit goes straight to LED3, bypassing shadow.
                    LED0         <= shadow[0];
                    LED1         <= shadow[1];
                    LED2         <= shadow[2];
                    LED3         <= rx_data[3:0];
                    digits_valid <= 1'b1;
                    idx          <= '0;
                end else begin
                    shadow[idx] <= rx_data[3:0];
                    idx         <= idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_digit_rx.sv
// Directed self-checking bench for uart_digit_rx at 10 clocks per tick.
// Honours RX_PARITY_EN when defined.
module tb_uart_digit_rx;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 10000;
    localparam int OS       = 16;
    localparam int DIV      = CLK_FREQ / (BAUD * OS);
    localparam int BIT_CLKS = DIV * OS;
`ifdef RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // 2 sync flops + 1 detect clock, half bit to start centre, full bits
    // up to the stop-bit centre, then the registered pulse.
    localparam int LAT = 3 + DIV * (OS / 2 + OS * (FRAME_BITS - 1));

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Rxd = 1'b1;
    logic [3:0] LED0, LED1, LED2, LED3;
    logic       digits_valid, frame_err, char_err, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int dv_n = 0, fe_n = 0, ce_n = 0;
    int dv_cyc = 0, fe_cyc = 0, ce_cyc = 0;
    int multi_n = 0, glitch_n = 0;
    logic [15:0] led_prev = 16'h0;

    uart_digit_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Rxd          (Rxd),
        .LED0         (LED0),
        .LED1         (LED1),
        .LED2         (LED2),
        .LED3         (LED3),
        .digits_valid (digits_valid),
        .frame_err    (frame_err),
        .char_err     (char_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (digits_valid) begin dv_n++; dv_cyc = cyc; end
        if (frame_err)    begin fe_n++; fe_cyc = cyc; end
        if (char_err)     begin ce_n++; ce_cyc = cyc; end
        if (int'(digits_valid) + int'(frame_err) + int'(char_err) > 1)
            multi_n++;
        if (!rst && !digits_valid && {LED0, LED1, LED2, LED3} != led_prev)
            glitch_n++;
        led_prev = {LED0, LED1, LED2, LED3};
    end

    task automatic hold_bit(input logic v);
        Rxd = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop,
                             input logic pflip, output int t0);
        @(negedge clk);
        t0 = cyc;
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
`ifdef RX_PARITY_EN
        hold_bit((^b) ^ pflip);
`else
        if (pflip) Rxd = 1'b1;
`endif
        hold_bit(stop);
        Rxd = 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({LED0, LED1, LED2, LED3} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_leds: got %h, expected 0000",
                     {LED0, LED1, LED2, LED3});
        end
        n_checks++;
        if ({digits_valid, frame_err, char_err, busy} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, expected 0000",
                     {digits_valid, frame_err, char_err, busy});
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_digits;
        int t;
        int dv0;
        dv0 = dv_n;
        send_byte("1", 1'b1, 1'b0, t);
        send_byte("2", 1'b1, 1'b0, t);
        send_byte("3", 1'b1, 1'b0, t);
        n_checks++;
        if ({LED0, LED1, LED2, LED3} !== 16'h0 || dv_n !== dv0) begin
            n_fail++;
            $display("FAIL digits_early: leds %h dv %0d, expected 0000 dv %0d",
                     {LED0, LED1, LED2, LED3}, dv_n, dv0);
        end
        send_byte("4", 1'b1, 1'b0, t);
        repeat (4) @(negedge clk);
        n_checks++;
        if (dv_n !== dv0 + 1) begin
            n_fail++;
            $display("FAIL digits_pulses: got %0d, expected %0d",
                     dv_n - dv0, 1);
        end
        n_checks++;
        if (dv_cyc !== t + LAT) begin
            n_fail++;
            $display("FAIL digits_latency: got cycle %0d, expected %0d",
                     dv_cyc, t + LAT);
        end
        n_checks++;
        if ({LED0, LED1, LED2, LED3} !== 16'h1234) begin
            n_fail++;
            $display("FAIL digits_leds: got %h, expected 1234",
                     {LED0, LED1, LED2, LED3});
        end
    endtask

    task automatic test_false_start;
        int p0;
        p0 = dv_n + fe_n + ce_n;
        @(negedge clk);
        Rxd = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL false_busy_rise: got %b, expected 1", busy);
        end
        repeat (20) @(negedge clk);
        Rxd = 1'b1;
        repeat (200) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL false_busy_fall: got %b, expected 0", busy);
        end
        n_checks++;
        if (dv_n + fe_n + ce_n !== p0) begin
            n_fail++;
            $display("FAIL false_pulses: got %0d, expected %0d",
                     dv_n + fe_n + ce_n, p0);
        end
        n_checks++;
        if ({LED0, LED1, LED2, LED3} !== 16'h1234) begin
            n_fail++;
            $display("FAIL false_leds: got %h, expected 1234",
                     {LED0, LED1, LED2, LED3});
        end
    endtask

    task automatic test_frame_err;
        int t;
        int fe0, dv0;
        fe0 = fe_n;
        dv0 = dv_n;
        send_byte("5", 1'b1, 1'b0, t);
        send_byte("9", 1'b0, 1'b0, t);
        repeat (2 * BIT_CLKS) @(negedge clk);
        n_checks++;
        if (fe_n !== fe0 + 1 || fe_cyc !== t + LAT) begin
            n_fail++;
            $display("FAIL frame_pulse: count %0d cycle %0d, expected %0d %0d",
                     fe_n - fe0, fe_cyc, 1, t + LAT);
        end
        send_byte("1", 1'b1, 1'b0, t);
        send_byte("1", 1'b1, 1'b0, t);
        send_byte("1", 1'b1, 1'b0, t);
        n_checks++;
        if ({LED0, LED1, LED2, LED3} !== 16'h1234 || dv_n !== dv0) begin
            n_fail++;
            $display("FAIL frame_hold: leds %h dv %0d, expected 1234 dv %0d",
                     {LED0, LED1, LED2, LED3}, dv_n, dv0);
        end
        send_byte("1", 1'b1, 1'b0, t);
        repeat (4) @(negedge clk);
        n_checks++;
        if ({LED0, LED1, LED2, LED3} !== 16'h1111 || dv_n !== dv0 + 1) begin
            n_fail++;
            $display("FAIL frame_after: leds %h dv %0d, expected 1111 dv %0d",
                     {LED0, LED1, LED2, LED3}, dv_n, dv0 + 1);
        end
    endtask

    task automatic test_char_err;
        int t;
        int ce0, dv0;
        ce0 = ce_n;
        dv0 = dv_n;
        send_byte("5", 1'b1, 1'b0, t);
        send_byte("A", 1'b1, 1'b0, t);
        repeat (4) @(negedge clk);
        n_checks++;
        if (ce_n !== ce0 + 1 || ce_cyc !== t + LAT) begin
            n_fail++;
            $display("FAIL char_pulse: count %0d cycle %0d, expected %0d %0d",
                     ce_n - ce0, ce_cyc, 1, t + LAT);
        end
        n_checks++;
        if ({LED0, LED1, LED2, LED3} !== 16'h1111) begin
            n_fail++;
            $display("FAIL char_hold: got %h, expected 1111",
                     {LED0, LED1, LED2, LED3});
        end
        send_byte("6", 1'b1, 1'b0, t);
        send_byte("7", 1'b1, 1'b0, t);
        send_byte("8", 1'b1, 1'b0, t);
        send_byte("9", 1'b1, 1'b0, t);
        repeat (4) @(negedge clk);
        n_checks++;
        if ({LED0, LED1, LED2, LED3} !== 16'h6789 || dv_n !== dv0 + 1) begin
            n_fail++;
            $display("FAIL char_after: leds %h dv %0d, expected 6789 dv %0d",
                     {LED0, LED1, LED2, LED3}, dv_n, dv0 + 1);
        end
    endtask

    task automatic test_reset_mid;
        int t;
        int p0;
        logic [7:0] b;
        b = "8";
        @(negedge clk);
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(b[i]);
        Rxd = b[4];
        repeat (BIT_CLKS / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({LED0, LED1, LED2, LED3} !== 16'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_out: leds %h busy %b, expected 0000 0",
                     {LED0, LED1, LED2, LED3}, busy);
        end
        p0 = dv_n + fe_n + ce_n;
        Rxd = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        n_checks++;
        if (dv_n + fe_n + ce_n !== p0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_quiet: pulses %0d busy %b, expected %0d 0",
                     dv_n + fe_n + ce_n, busy, p0);
        end
        send_byte("0", 1'b1, 1'b0, t);
        send_byte("0", 1'b1, 1'b0, t);
        send_byte("0", 1'b1, 1'b0, t);
        send_byte("7", 1'b1, 1'b0, t);
        repeat (4) @(negedge clk);
        n_checks++;
        if ({LED0, LED1, LED2, LED3} !== 16'h0007 || dv_n !== 1 + (p0 - fe_n - ce_n)) begin
            n_fail++;
            $display("FAIL midrst_after: leds %h, expected 0007",
                     {LED0, LED1, LED2, LED3});
        end
    endtask

`ifdef RX_PARITY_EN
    task automatic test_parity;
        int t;
        int fe0, dv0;
        fe0 = fe_n;
        dv0 = dv_n;
        send_byte("5", 1'b1, 1'b0, t);
        send_byte("3", 1'b1, 1'b1, t);
        repeat (4) @(negedge clk);
        n_checks++;
        if (fe_n !== fe0 + 1 || fe_cyc !== t + LAT) begin
            n_fail++;
            $display("FAIL parity_pulse: count %0d cycle %0d, expected %0d %0d",
                     fe_n - fe0, fe_cyc, 1, t + LAT);
        end
        send_byte("4", 1'b1, 1'b0, t);
        send_byte("3", 1'b1, 1'b0, t);
        send_byte("2", 1'b1, 1'b0, t);
        send_byte("1", 1'b1, 1'b0, t);
        repeat (4) @(negedge clk);
        n_checks++;
        if ({LED0, LED1, LED2, LED3} !== 16'h4321 || dv_n !== dv0 + 1) begin
            n_fail++;
            $display("FAIL parity_after: leds %h dv %0d, expected 4321 dv %0d",
                     {LED0, LED1, LED2, LED3}, dv_n, dv0 + 1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_digits();
        test_false_start();
        test_frame_err();
        test_char_err();
        test_reset_mid();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        n_checks++;
        if (multi_n !== 0) begin
            n_fail++;
            $display("FAIL onehot_pulses: got %0d cycles, expected 0", multi_n);
        end
        n_checks++;
        if (glitch_n !== 0) begin
            n_fail++;
            $display("FAIL led_stability: got %0d changes, expected 0",
                     glitch_n);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_digit_rx.md
UART_DIGIT_RX -- requirements
Module: uart_digit_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate.
REQ-003 Parameter OVERSAMPLE, default 16, sample ticks per bit.
REQ-004 clk  input  1  system clock; all logic on posedge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 Rxd  input  1  serial line, idle high, LSB first.
REQ-007 LED0..LED3  output  4 each  received digits 0-9, LED0 = first digit received.
REQ-008 digits_valid  output  1  one-cycle pulse when LED0..LED3 update.
REQ-009 frame_err  output  1  one-cycle pulse on bad stop bit (or parity, see Configuration).
REQ-010 char_err  output  1  one-cycle pulse on a byte outside ASCII '0'-'9'.
REQ-011 busy  output  1  high from start-bit detection until return to IDLE.

Function
REQ-012 Rxd SHALL pass a 2-flop synchronizer before any use; raw Rxd never reaches logic.
REQ-013 Tick divider SHALL pulse once every CLK_FREQ/(BAUD*OVERSAMPLE) clocks (integer divide); it is reset to 0 on each start detection.
REQ-014 Bit FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-015 IDLE -> START on synchronized Rxd = 0.
REQ-016 START: at tick OVERSAMPLE/2, Rxd = 1 -> IDLE (false start, no error pulse); Rxd = 0 -> DATA.
REQ-017 DATA: sample every OVERSAMPLE ticks, 8 bits, LSB first, into shift register; after bit 7 -> STOP (or PARITY).
REQ-018 STOP: sample once after OVERSAMPLE ticks; 1 = byte good, 0 = frame error; -> IDLE in the same cycle, so a start bit in the next clock is accepted.
REQ-019 Good byte 8'h30-8'h39: low nibble written to shadow digit slot[idx], idx increments.
REQ-020 Good byte outside 8'h30-8'h39: char_err pulse, idx := 0, shadow discarded.
REQ-021 Frame error: frame_err pulse, byte discarded, idx := 0.
REQ-022 On the 4th valid digit (idx = 3): all four shadow digits copied to LED0..LED3 in one clock, digits_valid pulses in that same clock, idx := 0.
REQ-023 LED0..LED3 SHALL change only on a digits_valid cycle; errors never alter them.
REQ-024 Latency: error/valid pulse occurs exactly 1 clock after the stop-bit sample tick.
REQ-025 At most one of digits_valid, frame_err, char_err is asserted per cycle.

Reset
REQ-026 rst asserted: FSM = IDLE, idx = 0, divider = 0, shadow = 0, LED0..LED3 = 4'h0, digits_valid = frame_err = char_err = busy = 0, synchronizer flops = 1.
REQ-027 Reset mid-byte aborts the byte with no error pulse; first full frame after release is received normally.

Configuration
REQ-028 Macro RX_PARITY_EN defined: one even-parity bit follows bit 7 in PARITY state; mismatch is treated exactly as a frame error (REQ-021), and the stop bit is still sampled.
REQ-029 Macro absent: 8N1 framing, no PARITY state, no parity logic synthesized.

Structure
REQ-030 Shared package holds: FSM state enum, ASCII_ZERO = 8'h30, ASCII_NINE = 8'h39, digit count constant 4.
REQ-031 One sub-module, uart_rx_byte: synchronizer, divider, bit FSM; outputs byte, byte_ok, byte_bad; uart_digit_rx holds digit assembly.

Verification (CLK_FREQ=1600000, BAUD=10000 -> 10 clocks/tick, 160 clocks/bit)
REQ-032 Send '1','2','3','4' back to back -> LED0..3 = 1,2,3,4, single digits_valid pulse 1 clock after 4th stop sample; LEDs stay 0 before.
REQ-033 Rxd low for 30 clocks then high -> no pulses, busy falls, LEDs unchanged.
REQ-034 Send '5','A','6','7','8','9' -> char_err pulse after 'A'; LED0..3 = 6,7,8,9.
REQ-035 After REQ-032, send '9' with stop bit held 0, then '1','1','1','1' -> frame_err pulse, LEDs stay 1,2,3,4 until final digits_valid gives 1,1,1,1.
REQ-036 Assert rst during bit 4 of a byte -> all outputs 0 immediately; then '0','0','0','7' -> LEDs 0,0,0,7.
REQ-037 With RX_PARITY_EN, '3' sent with odd parity bit -> frame_err pulse, idx reset; correct parity on four digits -> digits_valid.
